vid_fetch_ctrl: RTL and testbench
=================================

// Module: vid_fetch_ctrl
// PURPOSE
//  Pixel-fetch sequencer for the video controller: bus master that fills the RGB pixel FIFOs from frame memory.
//  Walks the frame from base_address one line at a time (line stride = lineinc), issuing 4-beat read bursts to memory.
//  Issues a burst only when the FIFOs have room. Stops at end of frame; restarts on frame_start.
// PARAMETERS
//  FIFO_DEPTH  16      entries per colour FIFO
//  BURST_LEN   4       beats per read burst (lenout code 2'b01); one pixel per beat, 4 bytes/pixel
//  CMD_READ    3'b010  cmdout code for read request
//  CMD_RDATA   3'b011  cmdin code marking a read-data beat
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous active-high reset
//  en            in   1   controller enable (cr[3])
//  frame_start   in   1   1-cycle pulse: start fetching a new frame
//  base_address  in   32  byte address of line 0
//  lineinc       in   32  byte stride between lines
//  hsize         in   13  displayed pixels per line; bits[1:0] ignored (hsize_eff = hsize & ~3)
//  vsize         in   13  displayed lines per frame
//  fifo_level    in   5   current FIFO occupancy, 0..FIFO_DEPTH
//  ackin         in   1   bus grant
//  selin         in   1   bus select, qualifies cmdin/addrdatain
//  cmdin         in   3   bus command in
//  addrdatain    in   32  bus data in; pixel = {R[23:16],G[15:8],B[7:0]}
//  reqout        out  2   bus bid; 2'b11 = high priority
//  cmdout        out  3   bus command out
//  lenout        out  2   burst length code
//  addrdataout   out  32  bus address out
//  reqtar        out  4   target; 4'b0000 = memory
//  fifo_wr       out  1   write strobe to all three colour FIFOs
//  fifo_wdata    out  24  {R,G,B} pixel written to the FIFOs
//  fifo_flush    out  1   1-cycle pulse: empty the FIFOs
//  line_done     out  1   1-cycle pulse: last beat of a line written
//  frame_done    out  1   1-cycle pulse: last beat of a frame written
//  busy          out  1   high in BID, ADDR or DATA
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. line_cnt = 0, pix_cnt = 0. Frame marked done; no fetch until frame_start.
//  States: IDLE, BID, ADDR, DATA, DONE. All outputs are registered.
//  frame_start (any state):
//   - load line_addr = pix_addr = base_address; line_cnt = pix_cnt = 0; pulse fifo_flush.
//   - If the state is DATA, set the discard flag: remaining beats of the in-flight burst are consumed, never written.
//   - Next state after the burst is IDLE (not DONE).
//  IDLE->BID when all hold: en; frame not done; fifo_level <= FIFO_DEPTH-BURST_LEN; hsize_eff != 0; vsize != 0.
//  BID: reqout = 2'b11 each cycle until ackin is sampled 1, then go to ADDR.
//   - If en drops in BID: go to IDLE, reqout = 0.
//  ADDR: exactly 1 cycle, with:
//   - cmdout = CMD_READ, addrdataout = pix_addr, lenout = 2'b01, reqtar = 4'b0000, reqout = 0.
//   - Then go to DATA. cmdout and addrdataout return to 0.
//  DATA: each cycle with selin && cmdin == CMD_RDATA is one beat.
//   - Next cycle: fifo_wr = 1, fifo_wdata = addrdatain[23:0].
//   - en low does not abort DATA; all 4 beats are still taken and written.
//  After the 4th beat: pix_addr += 16 (mod 2^32), pix_cnt += 4.
//   - If pix_cnt == hsize_eff: line_done pulse; line_addr += lineinc; pix_addr = new line_addr; pix_cnt = 0; line_cnt++.
//   - If line_cnt == vsize: also frame_done pulse; go to DONE. Otherwise go to IDLE.
//  line_done and frame_done pulse on the same cycle as the final fifo_wr.
//  Ignored inputs:
//   - Beats outside DATA.
//   - ackin outside BID.
//   - selin with any other cmdin.
//  DONE: no bids; leaves only on frame_start.
//  Only 1 burst outstanding at a time. FIFO never overflows because fifo_level <= DEPTH-4 is checked at issue.
//  Counters are 13 bits; address arithmetic is 32-bit and wraps.
// TESTING
//  1. reset held 2 cycles mid-BID -> all outputs 0, state IDLE, no bid until frame_start.
//  2. base=0x1000, lineinc=0x800, hsize=8, vsize=2, en=1, fifo_level=0, frame_start:
//     -> bursts at 0x1000, 0x1010, 0x1800, 0x1810; line_done x2; frame_done once; 16 fifo_wr.
//  3. fifo_level=13 -> no bid; drop level to 12 -> reqout=2'b11 on the next cycle.
//  4. ackin delayed 5 cycles -> reqout held 2'b11 for 5 cycles; ADDR cycle has cmdout=010, lenout=01, reqtar=0.
//  5. frame_start after beat 2 of a burst -> fifo_flush pulse; beats 3-4 not written; next burst address = base_address.
//  6. en=0 during DATA -> all 4 beats written, then IDLE with no further bids; hsize=3 -> no bids at all.

Source files
------------

// File: rtl/vid_fetch_ctrl.sv
// Pixel-fetch sequencer: bids for the bus and issues 4-beat read bursts that walk the frame
// line by line, writing each returned pixel into the RGB FIFOs.
module vid_fetch_ctrl #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter logic [2:0]  CMD_READ   = 3'b010,
    parameter logic [2:0]  CMD_RDATA  = 3'b011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        frame_start,
    input  logic [31:0] base_address,
    input  logic [31:0] lineinc,
    input  logic [12:0] hsize,
    input  logic [12:0] vsize,
    input  logic [4:0]  fifo_level,
    input  logic        ackin,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [31:0] addrdatain,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [3:0]  reqtar,
    output logic        fifo_wr,
    output logic [23:0] fifo_wdata,
    output logic        fifo_flush,
    output logic        line_done,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StBid, StAddr, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] line_addr_q, line_addr_d;
    logic [31:0] pix_addr_q, pix_addr_d;
    logic [12:0] line_cnt_q, line_cnt_d;
    logic [12:0] pix_cnt_q, pix_cnt_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic        discard_q, discard_d;
    logic        fin_q, fin_d;

    logic [1:0]  reqout_q, reqout_d;
    logic [2:0]  cmdout_q, cmdout_d;
    logic [1:0]  lenout_q, lenout_d;
    logic [31:0] addrdataout_q, addrdataout_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [23:0] fifo_wdata_q, fifo_wdata_d;
    logic        fifo_flush_q, fifo_flush_d;
    logic        line_done_q, line_done_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;

    logic [12:0] hsize_eff;
    logic [12:0] pix_cnt_inc;
    logic [31:0] next_line_addr;
    logic        beat, last_beat, level_ok;
    logic [7:0]  unused_data_hi;

    assign hsize_eff      = hsize & ~13'd3;
    assign pix_cnt_inc    = pix_cnt_q + 13'(BURST_LEN);
    assign next_line_addr = line_addr_q + lineinc;
    assign beat           = (state_q == StData) && selin && (cmdin == CMD_RDATA);
    assign last_beat      = beat_cnt_q == 2'(BURST_LEN - 1);
    assign level_ok       = fifo_level <= 5'(FIFO_DEPTH - BURST_LEN);
    assign unused_data_hi = addrdatain[31:24];

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        pix_addr_d   = pix_addr_q;
        line_cnt_d   = line_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        discard_d    = discard_q;
        fin_d        = fin_q;
        fifo_wr_d    = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        fifo_flush_d = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en && !fin_q && level_ok && hsize_eff != 13'd0 && vsize != 13'd0) begin
                    state_d = StBid;
                end
            end
            StBid: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (ackin) begin
                    state_d = StAddr;
                end
            end
            StAddr: state_d = StData;
            StData: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (!discard_q) begin
                        fifo_wr_d    = 1'b1;
                        fifo_wdata_d = addrdatain[23:0];
                    end
                    if (last_beat) begin
                        beat_cnt_d = 2'd0;
                        discard_d  = 1'b0;
                        state_d    = StIdle;
                        // A discarded burst belongs to the abandoned frame: pointers stay put.
                        if (!discard_q) begin
                            pix_addr_d = pix_addr_q + 32'(BURST_LEN * 4);
                            pix_cnt_d  = pix_cnt_inc;
                            if (pix_cnt_inc == hsize_eff) begin
                                line_done_d = 1'b1;
                                line_addr_d = next_line_addr;
                                pix_addr_d  = next_line_addr;
                                pix_cnt_d   = 13'd0;
                                line_cnt_d  = line_cnt_q + 13'd1;
                                if (line_cnt_q + 13'd1 == vsize) begin
                                    frame_done_d = 1'b1;
                                    fin_d        = 1'b1;
                                    state_d      = StDone;
                                end
                            end
                        end
                    end
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase

        if (frame_start) begin
            line_addr_d  = base_address;
            pix_addr_d   = base_address;
            line_cnt_d   = 13'd0;
            pix_cnt_d    = 13'd0;
            fin_d        = 1'b0;
            fifo_flush_d = 1'b1;
            fifo_wr_d    = 1'b0;
            line_done_d  = 1'b0;
            frame_done_d = 1'b0;
            // A read already on the bus must still be drained, but its data is dropped.
            unique case (state_q)
                StAddr: discard_d = 1'b1;
                StData: begin
                    if (beat && last_beat) begin
                        state_d = StIdle;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d        = (state_d == StBid) || (state_d == StAddr) || (state_d == StData);
        reqout_d      = (state_d == StBid) ? 2'b11 : 2'b00;
        cmdout_d      = (state_d == StAddr) ? CMD_READ : 3'b000;
        lenout_d      = (state_d == StAddr) ? 2'b01 : 2'b00;
        addrdataout_d = (state_d == StAddr) ? pix_addr_d : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            line_addr_q   <= 32'd0;
            pix_addr_q    <= 32'd0;
            line_cnt_q    <= 13'd0;
            pix_cnt_q     <= 13'd0;
            beat_cnt_q    <= 2'd0;
            discard_q     <= 1'b0;
            fin_q         <= 1'b1;
            reqout_q      <= 2'b00;
            cmdout_q      <= 3'b000;
            lenout_q      <= 2'b00;
            addrdataout_q <= 32'd0;
            fifo_wr_q     <= 1'b0;
            fifo_wdata_q  <= 24'd0;
            fifo_flush_q  <= 1'b0;
            line_done_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_addr_q   <= line_addr_d;
            pix_addr_q    <= pix_addr_d;
            line_cnt_q    <= line_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            discard_q     <= discard_d;
            fin_q         <= fin_d;
            reqout_q      <= reqout_d;
            cmdout_q      <= cmdout_d;
            lenout_q      <= lenout_d;
            addrdataout_q <= addrdataout_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_wdata_q  <= fifo_wdata_d;
            fifo_flush_q  <= fifo_flush_d;
            line_done_q   <= line_done_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign reqout      = reqout_q;
    assign cmdout      = cmdout_q;
    assign lenout      = lenout_q;
    assign addrdataout = addrdataout_q;
    assign reqtar      = 4'b0000;
    assign fifo_wr     = fifo_wr_q;
    assign fifo_wdata  = fifo_wdata_q;
    assign fifo_flush  = fifo_flush_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vid_fetch_ctrl.sv
// Scoreboard bench for vid_fetch_ctrl: stimulus pushes expected bursts and pixel writes,
// a monitor pops and compares whenever the DUT issues a read or writes the FIFOs.
module tb_vid_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, en, frame_start, ackin, selin;
    logic [31:0] base_address, lineinc, addrdatain;
    logic [12:0] hsize, vsize;
    logic [4:0]  fifo_level;
    logic [2:0]  cmdin;
    logic [1:0]  reqout, lenout;
    logic [2:0]  cmdout;
    logic [31:0] addrdataout;
    logic [3:0]  reqtar;
    logic        fifo_wr, fifo_flush, line_done, frame_done, busy;
    logic [23:0] fifo_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // {line_done, frame_done, pixel}
    logic [25:0] exp_wr_q[$];
    logic [31:0] exp_addr_q[$];
    logic [25:0] mon_e;
    logic [31:0] mon_a;

    always #5 clk = ~clk;

    vid_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .frame_start  (frame_start),
        .base_address (base_address),
        .lineinc      (lineinc),
        .hsize        (hsize),
        .vsize        (vsize),
        .fifo_level   (fifo_level),
        .ackin        (ackin),
        .selin        (selin),
        .cmdin        (cmdin),
        .addrdatain   (addrdatain),
        .reqout       (reqout),
        .cmdout       (cmdout),
        .lenout       (lenout),
        .addrdataout  (addrdataout),
        .reqtar       (reqtar),
        .fifo_wr      (fifo_wr),
        .fifo_wdata   (fifo_wdata),
        .fifo_flush   (fifo_flush),
        .line_done    (line_done),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (fifo_wr) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wr: got pixel 0x%06h expected no write", fifo_wdata);
            end else begin
                mon_e = exp_wr_q.pop_front();
                chk("wr_data", 32'(fifo_wdata), 32'(mon_e[23:0]));
                chk("line_done", 32'(line_done), 32'(mon_e[25]));
                chk("frame_done", 32'(frame_done), 32'(mon_e[24]));
            end
        end else if (line_done || frame_done) begin
            n_checks++;
            $display("FAIL stray_done: got line_done=%b frame_done=%b expected 0 without fifo_wr",
                     line_done, frame_done);
        end
        if (cmdout != 3'b000) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_cmd: got cmd %b addr 0x%08h expected none",
                         cmdout, addrdataout);
            end else begin
                mon_a = exp_addr_q.pop_front();
                chk("burst_addr", addrdataout, mon_a);
                chk("burst_cmd", 32'(cmdout), 32'h2);
                chk("burst_len", 32'(lenout), 32'h1);
                chk("burst_tar", 32'(reqtar), 32'h0);
                chk("burst_req", 32'(reqout), 32'h0);
            end
        end
    end

    task automatic pulse_fs();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic expect_idle(input int n, input string name);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (reqout != 2'b00 || busy) bad++;
        end
        chk(name, bad, 0);
    endtask

    // fs_after >= 0: frame_start lands after that many beats; later beats are not expected.
    task automatic serve_burst(input logic [31:0] addr, input int ack_dly, input bit ld,
                               input bit fd, input int fs_after, input bit drop_en);
        bit got = 1'b0;
        logic [31:0] data;
        for (int i = 0; i < 40 && !got; i++) begin
            if (reqout == 2'b11) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            $display("FAIL bid_timeout: got reqout=%b expected 11", reqout);
            return;
        end
        for (int i = 1; i < ack_dly; i++) begin
            @(negedge clk);
            chk("bid_hold", 32'(reqout), 32'h3);
        end
        exp_addr_q.push_back(addr);
        ackin = 1'b1;
        @(negedge clk);
        ackin = 1'b0;
        chk("busy_addr", 32'(busy), 32'h1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == fs_after) begin
                selin = 1'b0;
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
                chk("fifo_flush", 32'(fifo_flush), 32'h1);
            end
            data = {8'hC3, addr[15:0], 8'(b)};
            selin = 1'b1;
            cmdin = 3'b011;
            addrdatain = data;
            if (drop_en && b == 0) en = 1'b0;
            if (fs_after < 0 || b < fs_after)
                exp_wr_q.push_back({ld && b == 3, fd && b == 3, data[23:0]});
        end
        @(negedge clk);
        selin = 1'b0;
        cmdin = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got = 1'b0;
        reset = 1'b1; en = 1'b0; frame_start = 1'b0; ackin = 1'b0; selin = 1'b0;
        cmdin = 3'b000; addrdatain = 32'd0; fifo_level = 5'd0;
        base_address = 32'h1000; lineinc = 32'h800; hsize = 13'd8; vsize = 13'd2;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset held 2 cycles while bidding
        en = 1'b1;
        pulse_fs();
        for (int i = 0; i < 20 && !got; i++) begin
            if (reqout == 2'b11) got = 1'b1;
            else @(negedge clk);
        end
        chk("pre_reset_bid", 32'(reqout), 32'h3);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ctrl", {17'd0, reqout, cmdout, lenout, reqtar, fifo_wr, fifo_flush,
                           line_done, frame_done, busy}, 32'h0);
        chk("reset_addr", addrdataout, 32'h0);
        chk("reset_wdata", 32'(fifo_wdata), 32'h0);
        expect_idle(6, "reset_no_bid");

        // 2: full 8x2 frame
        pulse_fs();
        serve_burst(32'h1000, 1, 1'b0, 1'b0, -1, 1'b0);
        serve_burst(32'h1010, 1, 1'b1, 1'b0, -1, 1'b0);
        serve_burst(32'h1800, 1, 1'b0, 1'b0, -1, 1'b0);
        serve_burst(32'h1810, 1, 1'b1, 1'b1, -1, 1'b0);
        expect_idle(8, "frame_done_no_bid");

        // 3: FIFO room threshold
        en = 1'b0;
        fifo_level = 5'd13;
        pulse_fs();
        en = 1'b1;
        expect_idle(6, "level13_no_bid");
        fifo_level = 5'd12;
        @(negedge clk);
        chk("level12_bid", 32'(reqout), 32'h3);
        serve_burst(32'h1000, 1, 1'b0, 1'b0, -1, 1'b0);
        fifo_level = 5'd0;

        // 4: delayed grant
        en = 1'b0;
        repeat (2) @(negedge clk);
        pulse_fs();
        en = 1'b1;
        serve_burst(32'h1000, 5, 1'b0, 1'b0, -1, 1'b0);

        // 5: frame restart after beat 2 of the in-flight burst
        serve_burst(32'h1010, 1, 1'b0, 1'b0, 2, 1'b0);
        serve_burst(32'h1000, 1, 1'b0, 1'b0, -1, 1'b0);

        // 6: enable dropped mid-burst, then degenerate hsize
        serve_burst(32'h1010, 1, 1'b1, 1'b0, -1, 1'b1);
        expect_idle(10, "en_low_no_bid");
        hsize = 13'd3;
        en = 1'b1;
        pulse_fs();
        expect_idle(10, "hsize3_no_bid");

        repeat (3) @(negedge clk);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("addr_queue_drained", exp_addr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
